// File: rtl/oam_dma_arbiter.sv
// oam_dma_arbiter: owns the CPU memory bus and routes each access to one of three
// memory ports (ext 0000-FDFF, oam FE00-FE9F, hi FF00-FFFF). It also implements the
// DMA source-page register and the OAM DMA engine, which copies NBYTES bytes from
// {page,8'h00} to FE00+i at one byte per clock.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   cpu_r_addr/cpu_r_data CPU read port (combinational data)
//   cpu_w_addr/_data/_wen CPU write port
//   ext_r_addr/ext_r_data ext read port (CPU address, or DMA source during XFER)
//   oam_r_addr/oam_r_data oam read port
//   hi_r_addr/hi_r_data   hi read port
//   bus_w_addr/bus_w_data shared write bus (CPU, or FE00+idx / ext data during XFER)
//   ext_w_wen, oam_w_wen, hi_w_wen  per-region write enables
//   dma_active            high while the engine is copying
module oam_dma_arbiter #(
  parameter int unsigned NBYTES       = 160,
  parameter int unsigned START_DELAY  = 1,
  parameter logic [15:0] DMA_REG_ADDR = 16'hFF46
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] cpu_r_addr,
  output logic [7:0]  cpu_r_data,
  input  logic [15:0] cpu_w_addr,
  input  logic [7:0]  cpu_w_data,
  input  logic        cpu_w_wen,
  output logic [15:0] ext_r_addr,
  input  logic [7:0]  ext_r_data,
  output logic [7:0]  oam_r_addr,
  input  logic [7:0]  oam_r_data,
  output logic [7:0]  hi_r_addr,
  input  logic [7:0]  hi_r_data,
  output logic [15:0] bus_w_addr,
  output logic [7:0]  bus_w_data,
  output logic        ext_w_wen,
  output logic        oam_w_wen,
  output logic        hi_w_wen,
  output logic        dma_active
);

  typedef enum logic [1:0] {StIdle, StStart, StXfer} state_e;

  localparam logic [7:0] LastIdx = 8'(NBYTES - 1);
  localparam logic [3:0] DlyInit = 4'((START_DELAY > 0) ? (START_DELAY - 1) : 0);

  state_e      state_q, state_d;
  logic [7:0]  idx_q, idx_d;
  logic [3:0]  dly_q, dly_d;
  logic [7:0]  src_q, src_d;

  logic        xfer;
  logic [7:0]  eff_page;

  // Address decode; the DMA register is checked first so it wins over any region.
  logic        r_dma, r_void, r_oam, r_hi;
  logic        w_dma, w_void, w_oam, w_hi;
  logic        dma_wr;

  assign r_dma  = (cpu_r_addr == DMA_REG_ADDR);
  assign r_void = (cpu_r_addr >= 16'hFEA0) && (cpu_r_addr <= 16'hFEFF);
  assign r_oam  = (cpu_r_addr >= 16'hFE00) && (cpu_r_addr <= 16'hFE9F);
  assign r_hi   = (cpu_r_addr >= 16'hFF00);

  assign w_dma  = (cpu_w_addr == DMA_REG_ADDR);
  assign w_void = (cpu_w_addr >= 16'hFEA0) && (cpu_w_addr <= 16'hFEFF);
  assign w_oam  = (cpu_w_addr >= 16'hFE00) && (cpu_w_addr <= 16'hFE9F);
  assign w_hi   = (cpu_w_addr >= 16'hFF00);

  assign dma_wr = cpu_w_wen && w_dma;

  assign xfer       = (state_q == StXfer);
  assign dma_active = xfer;

  // Pages E0-FF mirror C0-DF (echo RAM), so the source is fetched from the mirror.
  assign eff_page = (src_q >= 8'hE0) ? (src_q - 8'h20) : src_q;

  // Read-side routing. During XFER the engine owns the ext read port.
  assign ext_r_addr = xfer ? {eff_page, idx_q} : cpu_r_addr;
  assign oam_r_addr = cpu_r_addr[7:0];
  assign hi_r_addr  = cpu_r_addr[7:0];

  always_comb begin
    cpu_r_data = ext_r_data;
    if (r_dma) begin
      cpu_r_data = src_q;
    end else if (r_void) begin
      cpu_r_data = 8'h00;
    end else if (r_oam) begin
      cpu_r_data = xfer ? 8'hFF : oam_r_data;
    end else if (r_hi) begin
      cpu_r_data = hi_r_data;
    end else begin
      cpu_r_data = xfer ? 8'hFF : ext_r_data;
    end
  end

  // Write-side routing. During XFER the shared bus carries the copy.
  assign bus_w_addr = xfer ? {8'hFE, idx_q} : cpu_w_addr;
  assign bus_w_data = xfer ? ext_r_data : cpu_w_data;

  always_comb begin
    ext_w_wen = 1'b0;
    oam_w_wen = xfer;
    hi_w_wen  = 1'b0;
    if (cpu_w_wen && !w_dma && !w_void) begin
      if (w_oam) begin
        if (!xfer) oam_w_wen = 1'b1;
      end else if (w_hi) begin
        hi_w_wen = 1'b1;
      end else if (!xfer) begin
        ext_w_wen = 1'b1;
      end
    end
  end

  // Engine next state. A register write restarts from any state, and takes
  // precedence over the final-byte return to idle.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    dly_d   = dly_q;
    src_d   = src_q;
    unique case (state_q)
      StStart: begin
        if (dly_q == 4'd0) begin
          state_d = StXfer;
        end else begin
          dly_d = dly_q - 4'd1;
        end
      end
      StXfer: begin
        idx_d = idx_q + 8'd1;
        if (idx_q == LastIdx) begin
          state_d = StIdle;
          idx_d   = 8'd0;
        end
      end
      default: ;
    endcase
    if (dma_wr) begin
      src_d = cpu_w_data;
      idx_d = 8'd0;
      if (START_DELAY > 0) begin
        state_d = StStart;
        dly_d   = DlyInit;
      end else begin
        state_d = StXfer;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      idx_q   <= 8'd0;
      dly_q   <= 4'd0;
      src_q   <= 8'hFF;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      dly_q   <= dly_d;
      src_q   <= src_d;
    end
  end

endmodule

// File: tb/tb_oam_dma_arbiter.sv
module tb_oam_dma_arbiter;
  localparam int SD = 1;
  localparam int NB = 160;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] cpu_r_addr, cpu_w_addr, ext_r_addr, bus_w_addr;
  logic [7:0]  cpu_r_data, cpu_w_data, ext_r_data, oam_r_addr, oam_r_data;
  logic [7:0]  hi_r_addr, hi_r_data, bus_w_data;
  logic        cpu_w_wen, ext_w_wen, oam_w_wen, hi_w_wen, dma_active;

  logic [7:0]  ext_mem [65536];
  logic [7:0]  oam_mem [256];
  logic [7:0]  hi_mem  [256];
  logic [7:0]  exp_oam [256];

  assign ext_r_data = ext_mem[ext_r_addr];
  assign oam_r_data = oam_mem[oam_r_addr];
  assign hi_r_data  = hi_mem[hi_r_addr];

  always #5 clk = ~clk;

  oam_dma_arbiter #(
    .NBYTES      (NB),
    .START_DELAY (SD),
    .DMA_REG_ADDR(16'hFF46)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cpu_r_addr(cpu_r_addr),
    .cpu_r_data(cpu_r_data),
    .cpu_w_addr(cpu_w_addr),
    .cpu_w_data(cpu_w_data),
    .cpu_w_wen (cpu_w_wen),
    .ext_r_addr(ext_r_addr),
    .ext_r_data(ext_r_data),
    .oam_r_addr(oam_r_addr),
    .oam_r_data(oam_r_data),
    .hi_r_addr (hi_r_addr),
    .hi_r_data (hi_r_data),
    .bus_w_addr(bus_w_addr),
    .bus_w_data(bus_w_data),
    .ext_w_wen (ext_w_wen),
    .oam_w_wen (oam_w_wen),
    .hi_w_wen  (hi_w_wen),
    .dma_active(dma_active)
  );

  int         n_assert = 0;
  int         n_fail   = 0;
  int         act_cycles;
  // Reference model: a transfer is described by the cycle count since the
  // register write (m_t = 1 is the first cycle after the write edge).
  logic [7:0] m_src;
  int         m_t;
  bit         m_valid;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit m_active();
    return m_valid && (m_t >= SD + 1) && (m_t <= SD + NB);
  endfunction

  function automatic int m_idx();
    return m_t - SD - 1;
  endfunction

  function automatic logic [7:0] m_eff();
    return (m_src >= 8'hE0) ? m_src - 8'h20 : m_src;
  endfunction

  function automatic logic [7:0] exp_read(input logic [15:0] a, input bit act);
    if (a == 16'hFF46) return m_src;
    if (a >= 16'hFEA0 && a <= 16'hFEFF) return 8'h00;
    if (a >= 16'hFE00 && a <= 16'hFE9F) return act ? 8'hFF : oam_mem[a[7:0]];
    if (a >= 16'hFF00) return hi_mem[a[7:0]];
    return act ? 8'hFF : ext_mem[a];
  endfunction

  // One clock cycle: drive, check against the model, clock, then update
  // memories and model from what was presented before the edge.
  task automatic tick(input logic [15:0] ra, input logic [15:0] wa, input logic [7:0] wd,
                      input logic we);
    bit          act;
    int          ix;
    logic [15:0] sa, ba;
    logic [7:0]  bd;
    logic        wo, wh;
    cpu_r_addr = ra;
    cpu_w_addr = wa;
    cpu_w_data = wd;
    cpu_w_wen  = we;
    #1;
    act = m_active();
    ix  = m_idx();
    if (dma_active === 1'b1) act_cycles++;
    chk("dma_active", dma_active, act);
    chk("cpu_r_data", cpu_r_data, exp_read(ra, act));
    chk("ext_w_wen", ext_w_wen, we && (wa < 16'hFE00) && !act);
    chk("hi_w_wen", hi_w_wen, we && (wa >= 16'hFF00) && (wa != 16'hFF46));
    if (act) begin
      sa = {m_eff(), 8'(ix)};
      chk("oam_w_wen_xfer", oam_w_wen, 1);
      chk("bus_w_addr", bus_w_addr, 16'hFE00 + ix);
      chk("ext_r_addr", ext_r_addr, sa);
      chk("bus_w_data", bus_w_data, ext_mem[sa]);
      exp_oam[ix] = ext_mem[sa];
    end else begin
      chk("oam_w_wen_cpu", oam_w_wen, we && (wa >= 16'hFE00) && (wa <= 16'hFE9F));
    end
    wo = oam_w_wen;
    wh = hi_w_wen;
    ba = bus_w_addr;
    bd = bus_w_data;
    @(posedge clk);
    if (wo === 1'b1) oam_mem[ba[7:0]] = bd;
    // The hi block sits on the CPU side: during XFER the shared bus carries the copy.
    if (wh === 1'b1) hi_mem[wa[7:0]] = wd;
    if (we && wa == 16'hFF46) begin
      m_src   = wd;
      m_valid = 1'b1;
      m_t     = 1;
    end else if (m_valid) begin
      m_t++;
      if (m_t > SD + NB) m_valid = 1'b0;
    end
    #1;
  endtask

  task automatic tick_rand();
    logic [15:0] ra, wa;
    logic [7:0]  wd;
    logic        we;
    case ($urandom_range(0, 5))
      0:       ra = 16'($urandom_range(0, 16'hFDFF));
      1:       ra = 16'hFE00 + 16'($urandom_range(0, 159));
      2:       ra = 16'hFEA0 + 16'($urandom_range(0, 95));
      3:       ra = 16'hFF00 + 16'($urandom_range(0, 255));
      4:       ra = 16'hFF46;
      default: ra = 16'hC100 + 16'($urandom_range(0, 767));
    endcase
    we = ($urandom_range(0, 3) == 0);
    if ($urandom_range(0, 1) == 0) wa = 16'hFF80 + 16'($urandom_range(0, 126));
    else wa = 16'hD000 + 16'($urandom_range(0, 4095));
    wd = 8'($urandom);
    tick(ra, wa, wd, we);
  endtask

  task automatic run_to_idx(input int target);
    int k = 0;
    while (!(m_active() && m_idx() == target) && k < 400) begin
      tick_rand();
      k++;
    end
    if (k >= 400) begin
      n_assert++;
      n_fail++;
      $error("FAIL reach_idx: observed timeout expected idx %0d", target);
    end
  endtask

  task automatic run_idle();
    int k = 0;
    while (m_valid && k < 400) begin
      tick_rand();
      k++;
    end
    if (k >= 400) begin
      n_assert++;
      n_fail++;
      $error("FAIL run_idle: observed timeout expected idle");
    end
    repeat (3) tick_rand();
  endtask

  task automatic cmp_model();
    for (int i = 0; i < NB; i++) chk("oam_model", oam_mem[i], exp_oam[i]);
  endtask

  initial begin
    rst_n      = 1'b0;
    cpu_r_addr = 16'hFF46;
    cpu_w_addr = 16'h0000;
    cpu_w_data = 8'h00;
    cpu_w_wen  = 1'b0;
    m_src      = 8'hFF;
    m_valid    = 1'b0;
    m_t        = 0;
    act_cycles = 0;
    for (int i = 0; i < 65536; i++) ext_mem[i] = 8'($urandom);
    for (int i = 0; i < NB; i++) ext_mem[16'hC100 + i] = 8'(i) ^ 8'h5A;
    for (int i = 0; i < 256; i++) begin
      oam_mem[i] = 8'($urandom);
      exp_oam[i] = oam_mem[i];
      hi_mem[i]  = 8'($urandom);
    end

    // Reset state
    #12;
    chk("rst_dma_active", dma_active, 0);
    chk("rst_oam_w_wen", oam_w_wen, 0);
    chk("rst_ext_w_wen", ext_w_wen, 0);
    chk("rst_hi_w_wen", hi_w_wen, 0);
    chk("rst_src_reg", cpu_r_data, 8'hFF);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (5) tick_rand();

    // Full C1 copy with CPU lockout probes mid-transfer
    act_cycles = 0;
    tick(16'hFF46, 16'hFF46, 8'hC1, 1'b1);
    run_to_idx(8);
    tick(16'h0150, 16'hC000, 8'h3C, 1'b1);
    chk("lock_ext_rd", cpu_r_data, 8'hFF);
    chk("lock_ext_wr", ext_w_wen, 0);
    tick(16'hFE10, 16'hFF80, 8'hA7, 1'b1);
    chk("lock_oam_rd", cpu_r_data, 8'hFF);
    tick(16'hFF80, 16'h0000, 8'h00, 1'b0);
    chk("hi_roundtrip", cpu_r_data, 8'hA7);
    run_idle();
    chk("active_len", act_cycles, NB);
    for (int i = 0; i < NB; i++) chk("oam_c1", oam_mem[i], 8'(i) ^ 8'h5A);
    cmp_model();

    // Echo page E3 copies from C3
    tick(16'hFF46, 16'hFF46, 8'hE3, 1'b1);
    tick(16'hFF46, 16'h0000, 8'h00, 1'b0);
    chk("src_e3", cpu_r_data, 8'hE3);
    run_idle();
    for (int i = 0; i < NB; i++) chk("oam_c3", oam_mem[i], ext_mem[16'hC300 + i]);

    // Restart at idx 50, then restart again on the final byte
    tick(16'hFF46, 16'hFF46, 8'hC1, 1'b1);
    run_to_idx(50);
    tick(16'hFF46, 16'hFF46, 8'hC2, 1'b1);
    for (int i = 0; i <= 50; i++) chk("restart_c1", oam_mem[i], 8'(i) ^ 8'h5A);
    for (int i = 51; i < NB; i++) chk("restart_keep", oam_mem[i], ext_mem[16'hC300 + i]);
    run_to_idx(NB - 1);
    tick(16'hFF46, 16'hFF46, 8'hE3, 1'b1);
    for (int i = 0; i < NB; i++) chk("oam_c2", oam_mem[i], ext_mem[16'hC200 + i]);
    cmp_model();

    // Asynchronous reset at idx 80 of the E3 transfer
    run_to_idx(80);
    cpu_r_addr = 16'hFF46;
    cpu_w_wen  = 1'b0;
    rst_n      = 1'b0;
    #1;
    chk("arst_dma_active", dma_active, 0);
    chk("arst_oam_w_wen", oam_w_wen, 0);
    chk("arst_src_reg", cpu_r_data, 8'hFF);
    m_valid = 1'b0;
    m_src   = 8'hFF;
    @(posedge clk);
    #2;
    rst_n = 1'b1;
    for (int i = 0; i < 80; i++) chk("arst_head", oam_mem[i], ext_mem[16'hC300 + i]);
    for (int i = 80; i < NB; i++) chk("arst_tail", oam_mem[i], ext_mem[16'hC200 + i]);
    cmp_model();
    repeat (10) tick_rand();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
